// File: rtl/spi_ram_bridge.sv
// spi_ram_bridge: SPI-slave command decoder with auto-incrementing burst access to an internal RAM
// and a sticky status register (frame_err, wrap_flag) that clears on read.
module spi_ram_bridge #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic MOSI,
   input  logic SS_n,
   output logic MISO,
   output logic wr_done,
   output logic busy
);
   localparam int SW = DATA_WIDTH > 8 ? DATA_WIDTH : 8;
   localparam int MB = SW > ADDR_WIDTH ? SW : ADDR_WIDTH;
   localparam int CW = $clog2(MB);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, TURN, RDATA, STAT, DRAIN} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [ADDR_WIDTH-1:0] ptr, ptr_n, addr_sh, ptr_inc;
   logic [DATA_WIDTH-1:0] rx, rx_n, word, mem_q;
   logic [SW-1:0] tx, tx_n, tx_word, tx_stat;
   logic cmd_hi, cmd_hi_n, rd, rd_n, frame_err, ferr_n, wrap_flag, wrap_n, wr_n, we, at_last;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   assign addr_sh = ADDR_WIDTH'({ptr, MOSI});
   assign word    = DATA_WIDTH'({rx, MOSI});
   assign at_last = ptr == LAST;
   assign ptr_inc = at_last ? '0 : ptr + 1'b1;
   assign mem_q   = mem[ptr];
   // outgoing words and status are left-aligned so MISO is always the top bit
   assign tx_word = SW'(mem_q) << (SW - DATA_WIDTH);
   assign tx_stat = SW'({6'b0, frame_err, wrap_flag}) << (SW - 8);
   assign we      = state == WDATA && !SS_n && cnt == CW'(DATA_WIDTH - 1);
   assign MISO    = (state == RDATA || state == STAT) && tx[SW-1];
   assign busy    = state != IDLE;
   always_ff @(posedge clk) begin
      if (we) mem[ptr] <= word;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ptr       <= '0;
         rx        <= '0;
         tx        <= '0;
         cmd_hi    <= 1'b0;
         rd        <= 1'b0;
         frame_err <= 1'b0;
         wrap_flag <= 1'b0;
         wr_done   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         ptr       <= ptr_n;
         rx        <= rx_n;
         tx        <= tx_n;
         cmd_hi    <= cmd_hi_n;
         rd        <= rd_n;
         frame_err <= ferr_n;
         wrap_flag <= wrap_n;
         wr_done   <= wr_n;
      end
   end
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      ptr_n    = ptr;
      rx_n     = rx;
      tx_n     = tx;
      cmd_hi_n = cmd_hi;
      rd_n     = rd;
      ferr_n   = frame_err;
      wrap_n   = wrap_flag;
      wr_n     = 1'b0;
      if (SS_n) begin
         state_n = IDLE;
         cnt_n   = '0;
         if (state == CMD || state == ADDR || (state == WDATA && cnt != '0)) ferr_n = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               cmd_hi_n = MOSI;
               state_n  = CMD;
            end
            CMD: begin
               cnt_n = '0;
               rd_n  = MOSI;
               if (!cmd_hi) state_n = ADDR;
               else if (MOSI) begin
                  state_n = STAT;
                  tx_n    = tx_stat;
               end else begin
                  state_n = DRAIN;
                  ferr_n  = 1'b1;
               end
            end
            ADDR: begin
               ptr_n = addr_sh;
               cnt_n = cnt + 1'b1;
               if (cnt == CW'(ADDR_WIDTH - 1)) begin
                  cnt_n = '0;
                  if ({1'b0, addr_sh} >= (ADDR_WIDTH + 1)'(MEM_DEPTH)) begin
                     ferr_n  = 1'b1;
                     state_n = DRAIN;
                  end else state_n = rd ? TURN : WDATA;
               end
            end
            WDATA: begin
               rx_n  = word;
               cnt_n = cnt + 1'b1;
               if (we) begin
                  cnt_n  = '0;
                  ptr_n  = ptr_inc;
                  wrap_n = wrap_flag | at_last;
                  wr_n   = 1'b1;
               end
            end
            TURN: begin
               tx_n    = tx_word;
               ptr_n   = ptr_inc;
               wrap_n  = wrap_flag | at_last;
               cnt_n   = '0;
               state_n = RDATA;
            end
            RDATA: begin
               // reload on the last bit so the next word follows with no gap
               if (cnt == CW'(DATA_WIDTH - 1)) begin
                  tx_n   = tx_word;
                  ptr_n  = ptr_inc;
                  wrap_n = wrap_flag | at_last;
                  cnt_n  = '0;
               end else begin
                  tx_n  = tx << 1;
                  cnt_n = cnt + 1'b1;
               end
            end
            STAT: begin
               tx_n  = tx << 1;
               cnt_n = cnt + 1'b1;
               if (cnt == CW'(7)) begin
                  ferr_n  = 1'b0;
                  wrap_n  = 1'b0;
                  state_n = DRAIN;
               end
            end
            DRAIN: state_n = DRAIN;
            default: state_n = IDLE;
         endcase
      end
   end
endmodule
